logic_unit_arbiter: RTL

Shares one 8-bit bitwise logic unit (OR/AND/XOR/NOT-A) among NREQ requesters in the processor datapath. It arbitrates round-robin, latches the winner's operands and opcode, computes the result and holds it in a single-entry output register with a valid/ready handshake. It sits between the register-read stage clients and the writeback path.

---
 rtl/logic_pkg.sv | 8 +
 rtl/rr_arbiter.sv | 28 ++
 rtl/logic_unit_arbiter.sv | 63 ++++++
 3 files changed

// File: rtl/logic_pkg.sv
// logic_pkg: opcode encodings and default datapath width for the shared logic unit
package logic_pkg;
  localparam int W_DEF = 8;
  localparam logic [1:0] OP_OR = 2'b00;
  localparam logic [1:0] OP_AND = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOTA = 2'b11;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin picker; req/ptr in, one-hot grant, grant_idx and any out
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW = 2
) (
  input logic [NREQ-1:0] req,
  input logic [IDW-1:0] ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0] grant_idx,
  output logic any
);
  logic [IDW:0] sum [NREQ];
  logic [IDW-1:0] cand [NREQ];
  for (genvar k = 0; k < NREQ; k++) begin : g_c
    assign sum[k] = {1'b0, ptr} + (IDW+1)'(k);
    assign cand[k] = sum[k] >= (IDW+1)'(NREQ) ? IDW'(sum[k] - (IDW+1)'(NREQ)) : sum[k][IDW-1:0];
  end
  always_comb begin
    grant_idx = '0;
    any = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--)
      if (req[cand[k]]) begin
        grant_idx = cand[k];
        any = 1'b1;
      end
  end
  assign grant = any ? NREQ'(1) << grant_idx : '0;
endmodule

// File: rtl/logic_unit_arbiter.sv
// logic_unit_arbiter: round-robin shared OR/AND/XOR/NOT-A unit; req_valid/req_ready/req_op/req_a/req_b in, res_valid/res_ready/res_data/res_id out
module logic_unit_arbiter
  import logic_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W = W_DEF,
  parameter int IDW = $clog2(NREQ)
) (
  input logic clk,
  input logic rst,
  input logic [NREQ-1:0] req_valid,
  input logic [2*NREQ-1:0] req_op,
  input logic [W*NREQ-1:0] req_a,
  input logic [W*NREQ-1:0] req_b,
  output logic [NREQ-1:0] req_ready,
  output logic res_valid,
  input logic res_ready,
  output logic [W-1:0] res_data,
  output logic [IDW-1:0] res_id
);
  logic [IDW-1:0] ptr, win;
  logic [NREQ-1:0] grant;
  logic any, accept;
  logic [1:0] op;
  logic [W-1:0] a, b, f;
  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req(req_valid),
    .ptr(ptr),
    .grant(grant),
    .grant_idx(win),
    .any(any)
  );
  assign req_ready = (!rst && (!res_valid || res_ready)) ? grant : '0;
  assign accept = |req_ready;
  assign op = req_op[2*int'(win) +: 2];
  assign a = req_a[W*int'(win) +: W];
  assign b = req_b[W*int'(win) +: W];
  always_comb begin
    f = '0;
    case (op)
      OP_OR: f = a | b;
      OP_AND: f = a & b;
      OP_XOR: f = a ^ b;
      OP_NOTA: f = ~a;
      default: f = '0;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_data <= '0;
      res_id <= '0;
      ptr <= '0;
    end else if (accept) begin
      res_valid <= 1'b1;
      res_data <= f;
      res_id <= win;
      ptr <= win == IDW'(NREQ - 1) ? '0 : win + 1'b1;
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end
endmodule
